// File: rtl/sign_mag_stream.sv
// Two-stage valid/ready converter from two's-complement to sign-magnitude.
// Optional most-negative clamping and saturation-event counter: `SIGN_MAG_SAT_EN.
module sign_mag_stream #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_sat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_data_reg;
  logic             s1_sign_reg;
  logic             s1_mneg_reg;

  logic             s2_valid_reg;
  logic             s2_sign_reg;
  logic [WIDTH-1:0] s2_mag_reg;
  logic             s2_sat_reg;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] mag_next;
  logic             sat_next;

  // Ready ripples back combinationally so a full pipe resumes without a bubble.
  always_comb begin
    s2_adv   = !s2_valid_reg || out_ready;
    s1_adv   = !s1_valid_reg || s2_adv;
    in_ready = s1_adv;
  end

  always_comb begin
    mag_next = s1_sign_reg ? (~s1_data_reg + ONE) : s1_data_reg;
    sat_next = 1'b0;
`ifdef SIGN_MAG_SAT_EN
    if (s1_mneg_reg) begin
      mag_next = MAX_POS;
      sat_next = 1'b1;
    end
`else
    // 2^(WIDTH-1) fits as an unsigned magnitude, so no clamping is needed.
    if (s1_mneg_reg) begin
      mag_next = MOST_NEG;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_sign_reg  <= 1'b0;
      s1_mneg_reg  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg <= in_data;
        s1_sign_reg <= in_data[WIDTH-1];
        s1_mneg_reg <= (in_data == MOST_NEG);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_mag_reg   <= '0;
      s2_sat_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_mag_reg  <= mag_next;
        s2_sat_reg  <= sat_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_sign  = s2_sign_reg;
  assign out_mag   = s2_mag_reg;

`ifdef SIGN_MAG_SAT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             cnt_inc;

  assign cnt_inc = s2_valid_reg && out_ready && s2_sat_reg && (cnt_reg != {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (cnt_inc) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_sat   = s2_sat_reg;
  assign sat_count = cnt_reg;
`else
  logic unused_sat_inputs;
  assign unused_sat_inputs = cnt_clr ^ s2_sat_reg;
  assign out_sat   = 1'b0;
  assign sat_count = '0;
`endif

endmodule
